// File: rtl/tb4004_pkg.sv
// Shared types and sizes for the 4004 testbench-system data RAM path.
package tb4004_pkg;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational two-way requester pick: round-robin or fixed port-0 priority on a tie.
module ram_arb_pick
  import tb4004_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic rr_last_i,
  input  logic mode_i,
  output logic sel_o,
  output logic any_o
);

  always_comb begin
    any_o = req0_i | req1_i;
    sel_o = req1_i;
    if (req0_i && req1_i) begin
      sel_o = (mode_i == PRIO_FIXED) ? 1'b0 : ~rr_last_i;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the 4096x4 data RAM: one access per cycle, read data at latency 1,
// optional locked ownership with a bounded hold time.
module ram_arbiter
  import tb4004_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int MAX_HOLD  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0Req,
  input  logic                  p0We,
  input  logic                  p0Lock,
  input  logic [RAM_ADDR_W-1:0] p0Addr,
  input  logic [RAM_DATA_W-1:0] p0WData,
  output logic                  p0Gnt,
  output logic                  p0RValid,
  output logic [RAM_DATA_W-1:0] p0RData,
  input  logic                  p1Req,
  input  logic                  p1We,
  input  logic                  p1Lock,
  input  logic [RAM_ADDR_W-1:0] p1Addr,
  input  logic [RAM_DATA_W-1:0] p1WData,
  output logic                  p1Gnt,
  output logic                  p1RValid,
  output logic [RAM_DATA_W-1:0] p1RData,
  output logic                  ramWe,
  output logic                  ramRe,
  output logic [RAM_ADDR_W-1:0] ramAddr,
  output logic [RAM_DATA_W-1:0] ramDataIn,
  input  logic [RAM_DATA_W-1:0] ramDataOut
);

  localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

  logic [1:0]            req, we, lock;
  logic [RAM_ADDR_W-1:0] addr  [2];
  logic [RAM_DATA_W-1:0] wdata [2];

  arb_state_e            state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  rr_last_q, rr_last_d;
  logic                  rtag_vld_q, rtag_vld_d;
  logic                  rtag_port_q, rtag_port_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic [RAM_DATA_W-1:0] wdata_q, wdata_d;

  logic pick_sel, pick_any;
  logic gnt_vld, gnt_port, own_port;

  assign req      = {p1Req, p0Req};
  assign we       = {p1We, p0We};
  assign lock     = {p1Lock, p0Lock};
  assign addr[0]  = p0Addr;
  assign addr[1]  = p1Addr;
  assign wdata[0] = p0WData;
  assign wdata[1] = p1WData;

  ram_arb_pick u_pick (
    .req0_i   (p0Req),
    .req1_i   (p1Req),
    .rr_last_i(rr_last_q),
    .mode_i   (PRIO_MODE != 0),
    .sel_o    (pick_sel),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rr_last_d = rr_last_q;
    gnt_vld   = 1'b0;
    gnt_port  = 1'b0;
    own_port  = (state_q == ARB_OWN1);
    case (state_q)
      ARB_IDLE: begin
        gnt_vld  = pick_any;
        gnt_port = pick_sel;
        if (pick_any && lock[pick_sel]) begin
          state_d = pick_sel ? ARB_OWN1 : ARB_OWN0;
          hold_d  = HOLD_ONE;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        gnt_vld  = req[own_port];
        gnt_port = own_port;
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        // Granted-without-lock and idle-without-lock both reduce to lock==0.
        if (!lock[own_port] || (hold_q == HOLD_LAST)) begin
          state_d = ARB_IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        hold_d  = '0;
      end
    endcase
    if (rst) gnt_vld = 1'b0;
    if (gnt_vld) rr_last_d = gnt_port;
    rtag_vld_d  = gnt_vld && !we[gnt_port];
    rtag_port_d = gnt_port;
    addr_d      = gnt_vld ? addr[gnt_port]  : addr_q;
    wdata_d     = gnt_vld ? wdata[gnt_port] : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      hold_q      <= '0;
      rr_last_q   <= 1'b1;
      rtag_vld_q  <= 1'b0;
      rtag_port_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rr_last_q   <= rr_last_d;
      rtag_vld_q  <= rtag_vld_d;
      rtag_port_q <= rtag_port_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign p0Gnt     = gnt_vld && !gnt_port;
  assign p1Gnt     = gnt_vld && gnt_port;
  assign ramWe     = gnt_vld && we[gnt_port];
  assign ramRe     = gnt_vld && !we[gnt_port];
  assign ramAddr   = rst ? '0 : addr_d;
  assign ramDataIn = rst ? '0 : wdata_d;

  // Reset in the data-return cycle must suppress the already-registered valid.
  assign p0RValid = rtag_vld_q && !rtag_port_q && !rst;
  assign p1RValid = rtag_vld_q && rtag_port_q && !rst;
  assign p0RData  = p0RValid ? ramDataOut : '0;
  assign p1RData  = p1RValid ? ramDataOut : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: one round-robin and one fixed-priority instance,
// each backed by a behavioural write-first RAM.
module tb_ram_arbiter;

  logic        clk;
  logic        rst [2];
  logic        rq  [2][2];
  logic        wr  [2][2];
  logic        lk  [2][2];
  logic [11:0] ad  [2][2];
  logic [3:0]  wd  [2][2];
  logic        gn  [2][2];
  logic        rv  [2][2];
  logic [3:0]  rd  [2][2];
  logic        rwe [2];
  logic        rre [2];
  logic [11:0] radr[2];
  logic [3:0]  rdin[2];

  typedef struct {
    int         port;
    logic [3:0] data;
  } rd_exp_t;

  rd_exp_t    sbq[$];
  logic [3:0] shadow[int];
  int         n_cmp = 0;
  int         n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ram_init(input int a);
    return (a == 32'h123) ? 4'hA : 4'(a ^ (a >> 4));
  endfunction

  function automatic logic [3:0] sh_rd(input int d, input int a);
    return shadow.exists(d * 4096 + a) ? shadow[d * 4096 + a] : ram_init(a);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] mem[int];
    logic [3:0] rdo;

    always @(posedge clk) begin
      if (rwe[g]) mem[int'(radr[g])] = rdin[g];
      if (rre[g]) rdo <= mem.exists(int'(radr[g])) ? mem[int'(radr[g])] : ram_init(int'(radr[g]));
    end

    ram_arbiter #(.PRIO_MODE(g), .MAX_HOLD(16)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .p0Req     (rq[g][0]),
      .p0We      (wr[g][0]),
      .p0Lock    (lk[g][0]),
      .p0Addr    (ad[g][0]),
      .p0WData   (wd[g][0]),
      .p0Gnt     (gn[g][0]),
      .p0RValid  (rv[g][0]),
      .p0RData   (rd[g][0]),
      .p1Req     (rq[g][1]),
      .p1We      (wr[g][1]),
      .p1Lock    (lk[g][1]),
      .p1Addr    (ad[g][1]),
      .p1WData   (wd[g][1]),
      .p1Gnt     (gn[g][1]),
      .p1RValid  (rv[g][1]),
      .p1RData   (rd[g][1]),
      .ramWe     (rwe[g]),
      .ramRe     (rre[g]),
      .ramAddr   (radr[g]),
      .ramDataIn (rdin[g]),
      .ramDataOut(rdo)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs(input int d);
    for (int p = 0; p < 2; p++) begin
      rq[d][p] = 1'b0;
      wr[d][p] = 1'b0;
      lk[d][p] = 1'b0;
    end
  endtask

  // One clock cycle on instance d with expected grant vector eg = {p1Gnt, p0Gnt}.
  task automatic step(input int d, input logic [1:0] eg);
    rd_exp_t    e;
    logic [1:0] rvv;
    #7;
    rvv = {rv[d][1], rv[d][0]};
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("rvalid", 32'(rvv), (e.port == 1) ? 32'd2 : 32'd1);
      check("rdata", 32'(rd[d][e.port]), 32'(e.data));
    end else begin
      check("rvalid_idle", 32'(rvv), 32'd0);
    end
    check("gnt", 32'({gn[d][1], gn[d][0]}), 32'(eg));
    if (rst[d]) begin
      check("rst_ram_en", 32'({rwe[d], rre[d]}), 32'd0);
      check("rst_ram_addr", 32'(radr[d]), 32'd0);
      check("rst_ram_din", 32'(rdin[d]), 32'd0);
    end
    for (int p = 0; p < 2; p++) begin
      if (eg[p]) begin
        if (wr[d][p]) begin
          shadow[d * 4096 + int'(ad[d][p])] = wd[d][p];
        end else begin
          e.port = p;
          e.data = sh_rd(d, int'(ad[d][p]));
          sbq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] v;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      clear_inputs(d);
      for (int p = 0; p < 2; p++) begin
        ad[d][p] = '0;
        wd[d][p] = '0;
      end
    end
    @(posedge clk);
    #1;

    // Requests during reset are ignored and the RAM side stays quiet.
    rq[0][0] = 1'b1; rq[0][1] = 1'b1; ad[0][0] = 12'h3A5; ad[0][1] = 12'h1C2;
    rq[1][0] = 1'b1;
    step(0, 2'b00);
    step(1, 2'b00);
    clear_inputs(0);
    clear_inputs(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step(0, 2'b00);

    // Round-robin tie: alternate starting with port 0.
    rq[0][0] = 1'b1; ad[0][0] = 12'h100;
    rq[0][1] = 1'b1; ad[0][1] = 12'h200;
    for (int i = 0; i < 8; i++) begin
      step(0, (i % 2 == 0) ? 2'b01 : 2'b10);
      ad[0][i % 2] = ad[0][i % 2] + 12'd1;
    end
    clear_inputs(0);
    step(0, 2'b00);

    // Single read of a preloaded location.
    rq[0][0] = 1'b1; ad[0][0] = 12'h123;
    step(0, 2'b01);
    clear_inputs(0);
    step(0, 2'b00);

    // Write then immediate read of the same address returns the new data.
    rq[0][0] = 1'b1; wr[0][0] = 1'b1; ad[0][0] = 12'h7FF; wd[0][0] = 4'h5;
    step(0, 2'b01);
    wr[0][0] = 1'b0;
    step(0, 2'b01);
    clear_inputs(0);
    step(0, 2'b00);
    check("addr_hold", 32'(radr[0]), 32'h7FF);

    // Locked read-modify-write by port 0 with port 1 waiting.
    rq[0][0] = 1'b1; lk[0][0] = 1'b1; ad[0][0] = 12'h050;
    step(0, 2'b01);
    v = sh_rd(0, 32'h050);
    rq[0][0] = 1'b0;
    rq[0][1] = 1'b1; wr[0][1] = 1'b1; ad[0][1] = 12'h060; wd[0][1] = 4'h3;
    step(0, 2'b00);
    rq[0][0] = 1'b1; wr[0][0] = 1'b1; lk[0][0] = 1'b0; wd[0][0] = v + 4'd1;
    step(0, 2'b01);
    rq[0][0] = 1'b0; wr[0][0] = 1'b0;
    step(0, 2'b10);
    wr[0][1] = 1'b0; ad[0][1] = 12'h050;
    step(0, 2'b10);
    clear_inputs(0);
    step(0, 2'b00);

    // Port 1 locked block write: 16 grants, forced release, then port 0.
    rq[0][1] = 1'b1; wr[0][1] = 1'b1; lk[0][1] = 1'b1;
    ad[0][1] = 12'h000; wd[0][1] = 4'h5;
    step(0, 2'b10);
    rq[0][0] = 1'b1; ad[0][0] = 12'h00F;
    for (int i = 1; i < 16; i++) begin
      ad[0][1] = 12'(i);
      wd[0][1] = 4'(i) ^ 4'h5;
      step(0, 2'b10);
    end
    ad[0][1] = 12'h010; wd[0][1] = 4'hC;
    step(0, 2'b01);
    rq[0][0] = 1'b0; lk[0][1] = 1'b0;
    step(0, 2'b10);
    clear_inputs(0);
    step(0, 2'b00);

    // Fixed priority: port 0 always wins until it drops.
    rq[1][0] = 1'b1; ad[1][0] = 12'h400;
    rq[1][1] = 1'b1; ad[1][1] = 12'h500;
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b01);
      ad[1][0] = ad[1][0] + 12'd1;
    end
    rq[1][0] = 1'b0;
    step(1, 2'b10);
    clear_inputs(1);
    step(1, 2'b00);

    // Reset one cycle after a locked read grant drops data, lock and arbitration history.
    rq[0][1] = 1'b1; lk[0][1] = 1'b1; ad[0][1] = 12'h222;
    step(0, 2'b10);
    sbq.delete();
    rst[0] = 1'b1; rq[0][0] = 1'b1; ad[0][0] = 12'h333;
    step(0, 2'b00);
    rst[0] = 1'b0; lk[0][1] = 1'b0;
    step(0, 2'b01);
    clear_inputs(0);
    step(0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
